// File: rtl/seg7_scan_controller.sv
// Eight-digit seven-segment scan controller: refresh timing, frame-aligned double
// buffering of hex values and decimal points, and overflow blink of the decimal points.
module seg7_scan_controller #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  overflow,
  input  logic                  load,
  output logic                  load_pending,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [TICK_W-1:0]     tick_r, tick_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [4*N_DIGITS-1:0] pend_value_r, pend_value_s;
  logic [N_DIGITS-1:0]   pend_dp_r, pend_dp_s;
  logic [4*N_DIGITS-1:0] shad_value_r, shad_value_s;
  logic [N_DIGITS-1:0]   shad_dp_r, shad_dp_s;
  logic                  load_pending_r, load_pending_s;
  logic                  overflow_r;
  logic [FRM_W-1:0]      frame_cnt_r, frame_cnt_s;
  logic                  blink_phase_r, blink_phase_s;
  // Set until the first frame boundary so the post-reset frame does not pulse frame_start.
  logic                  first_frame_r, first_frame_s;
  logic                  boundary_s;

  logic [N_DIGITS-1:0]   an_r, an_s;
  logic [6:0]            seg_r, seg_s;
  logic                  dp_r, dp_s;
  logic                  frame_start_r, frame_start_s;
  logic [3:0]            digit_s;

  // Next-state logic: scan timing, buffer transfers and blink counter.
  always_comb begin
    tick_s         = tick_r;
    idx_s          = idx_r;
    boundary_s     = 1'b0;
    pend_value_s   = pend_value_r;
    pend_dp_s      = pend_dp_r;
    shad_value_s   = shad_value_r;
    shad_dp_s      = shad_dp_r;
    load_pending_s = load_pending_r;
    frame_cnt_s    = frame_cnt_r;
    blink_phase_s  = blink_phase_r;
    first_frame_s  = first_frame_r;

    if (tick_r == TICK_LAST) begin
      tick_s = {TICK_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_s      = {IDX_W{1'b0}};
        boundary_s = 1'b1;
      end else begin
        idx_s = idx_r + IDX_W'(1);
      end
    end else begin
      tick_s = tick_r + TICK_W'(1);
    end

    // A load landing on the boundary bypasses pending straight into the shadow.
    if (boundary_s && load) begin
      pend_value_s   = value;
      pend_dp_s      = dp_mask;
      shad_value_s   = value;
      shad_dp_s      = dp_mask;
      load_pending_s = 1'b0;
    end else if (boundary_s) begin
      if (load_pending_r) begin
        shad_value_s = pend_value_r;
        shad_dp_s    = pend_dp_r;
      end else begin
        shad_value_s = shad_value_r;
        shad_dp_s    = shad_dp_r;
      end
      load_pending_s = 1'b0;
    end else if (load) begin
      pend_value_s   = value;
      pend_dp_s      = dp_mask;
      load_pending_s = 1'b1;
    end else begin
      load_pending_s = load_pending_r;
    end

    if (boundary_s) begin
      first_frame_s = 1'b0;
    end else begin
      first_frame_s = first_frame_r;
    end

    // Phase idles at 1 so the first overflow frame already lights the points.
    if (!overflow_r) begin
      frame_cnt_s   = {FRM_W{1'b0}};
      blink_phase_s = 1'b1;
    end else if (boundary_s) begin
      if (frame_cnt_r == FRM_LAST) begin
        frame_cnt_s   = {FRM_W{1'b0}};
        blink_phase_s = ~blink_phase_r;
      end else begin
        frame_cnt_s   = frame_cnt_r + FRM_W'(1);
        blink_phase_s = blink_phase_r;
      end
    end else begin
      frame_cnt_s   = frame_cnt_r;
      blink_phase_s = blink_phase_r;
    end
  end

  // Output decode from the current digit index and shadow contents.
  always_comb begin
    an_s    = {N_DIGITS{1'b1}};
    digit_s = shad_value_r[{idx_r, 2'b00} +: 4];
    seg_s   = hex_to_seg(digit_s);
    dp_s    = ~(shad_dp_r[idx_r] | (overflow_r & blink_phase_r));
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        an_s[k] = 1'b0;
      end else begin
        an_s[k] = 1'b1;
      end
    end
    frame_start_s = (idx_r == {IDX_W{1'b0}}) && (tick_r == {TICK_W{1'b0}}) && !first_frame_r;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_r         <= {TICK_W{1'b0}};
      idx_r          <= {IDX_W{1'b0}};
      pend_value_r   <= {(4*N_DIGITS){1'b0}};
      pend_dp_r      <= {N_DIGITS{1'b0}};
      shad_value_r   <= {(4*N_DIGITS){1'b0}};
      shad_dp_r      <= {N_DIGITS{1'b0}};
      load_pending_r <= 1'b0;
      overflow_r     <= 1'b0;
      frame_cnt_r    <= {FRM_W{1'b0}};
      blink_phase_r  <= 1'b1;
      first_frame_r  <= 1'b1;
      an_r           <= {N_DIGITS{1'b1}};
      seg_r          <= 7'b1111111;
      dp_r           <= 1'b1;
      frame_start_r  <= 1'b0;
    end else begin
      tick_r         <= tick_s;
      idx_r          <= idx_s;
      pend_value_r   <= pend_value_s;
      pend_dp_r      <= pend_dp_s;
      shad_value_r   <= shad_value_s;
      shad_dp_r      <= shad_dp_s;
      load_pending_r <= load_pending_s;
      overflow_r     <= overflow;
      frame_cnt_r    <= frame_cnt_s;
      blink_phase_r  <= blink_phase_s;
      first_frame_r  <= first_frame_s;
      an_r           <= an_s;
      seg_r          <= seg_s;
      dp_r           <= dp_s;
      frame_start_r  <= frame_start_s;
    end
  end

  assign load_pending = load_pending_r;
  assign an           = an_r;
  assign seg          = seg_r;
  assign dp           = dp_r;
  assign frame_start  = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: a cycle-position reference model queues the
// expected outputs of every clock edge and a negedge monitor compares them against the DUT.
module tb_seg7_scan_controller;

  localparam int ND = 8;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   value;
  logic [7:0]    dp_mask;
  logic          overflow;
  logic          load;
  logic          load_pending;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  seg7_scan_controller #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_mask(dp_mask),
    .overflow(overflow), .load(load), .load_pending(load_pending),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       lp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned model_t = 0;  // edges since reset release = scan position of the next edge
  logic [6:0]  seg_tab [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, expv);
    end
  endtask

  // Reference model: outputs follow from scan position, buffered values and blink count.
  initial begin
    exp_t        e;
    int          digit;
    bit          bnd;
    logic [31:0] shad_v, pend_v;
    logic [7:0]  shad_d, pend_d;
    logic        lp_m, ovf_m;
    int unsigned nb_m;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    shad_v = 32'h0; pend_v = 32'h0; shad_d = 8'h0; pend_d = 8'h0;
    lp_m = 1'b0; ovf_m = 1'b0; nb_m = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0; e.lp = 1'b0;
        model_t = 0; shad_v = 32'h0; pend_v = 32'h0; shad_d = 8'h0; pend_d = 8'h0;
        lp_m = 1'b0; ovf_m = 1'b0; nb_m = 0;
      end else begin
        digit = (model_t / RD) % ND;
        bnd   = (model_t % FRAME) == FRAME - 1;
        e.an  = ~(8'd1 << digit);
        e.seg = seg_tab[shad_v[4*digit +: 4]];
        e.dp  = !(shad_d[digit] || (ovf_m && ((nb_m / BF) % 2 == 0)));
        e.fs  = (model_t % FRAME == 0) && (model_t != 0);
        if (bnd && load) begin
          pend_v = value; pend_d = dp_mask; shad_v = value; shad_d = dp_mask; lp_m = 1'b0;
        end else if (bnd) begin
          if (lp_m) begin
            shad_v = pend_v; shad_d = pend_d;
          end
          lp_m = 1'b0;
        end else if (load) begin
          pend_v = value; pend_d = dp_mask; lp_m = 1'b1;
        end
        e.lp = lp_m;
        if (!ovf_m) nb_m = 0;
        else if (bnd) nb_m++;
        ovf_m = overflow;
        model_t++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: pop one expectation per edge and compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", {24'h0, an}, {24'h0, e.an});
        check("seg", {25'h0, seg}, {25'h0, e.seg});
        check("dp", {31'h0, dp}, {31'h0, e.dp});
        check("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
        check("load_pending", {31'h0, load_pending}, {31'h0, e.lp});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int unsigned pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (model_t % FRAME == pos) return;
      @(negedge clk);
    end
    n_bad++;
    $display("FAIL wait_pos: scan position %0d not reached, at %0d", pos, model_t % FRAME);
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] m);
    value = v; dp_mask = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = $urandom; dp_mask = 8'($urandom);
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = 32'h0; dp_mask = 8'h0; overflow = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(40);
    // Decode of every digit position.
    pulse_load(32'h76543210, 8'h00);
    run(80);
    // Mid-frame load stays pending until the frame boundary.
    wait_pos(10);
    pulse_load(32'hFFFFFFFF, 8'h00);
    run(40);
    // Load in the exact wrap cycle goes straight to the display.
    wait_pos(31);
    pulse_load(32'h0000000A, 8'h00);
    run(40);
    // Decimal point plus overflow blink, then overflow removal.
    pulse_load($urandom, 8'h01);
    run(40);
    overflow = 1'b1;
    run(FRAME * 8);
    overflow = 1'b0;
    run(40);
    // Randomized traffic with occasional overflow toggles and resets.
    for (int it = 0; it < 300; it++) begin
      run($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) overflow = ~overflow;
      if ($urandom_range(0, 59) == 0) begin
        reset_n = 1'b0;
        run($urandom_range(1, 3));
        reset_n = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        pulse_load($urandom, 8'($urandom));
      end else begin
        value = $urandom;
      end
    end
    // Reset during digit 5 with a load pending.
    overflow = 1'b0;
    wait_pos(12);
    pulse_load(32'h89ABCDEF, 8'hFF);
    wait_pos(21);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(80);
    run(2);
    check("compare_volume", (n_cmp >= 10000) ? 32'd1 : 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexing controller for the Nexys 4 DDR eight-digit seven-segment display. It owns the shared cathode bus (segments plus decimal point) and hands it to one anode at a time on a fixed refresh schedule. Hex values are double-buffered so they only change on frame boundaries. The decimal point of every digit blinks while the arithmetic datapath reports overflow.

## Interface
- N_DIGITS, 8: number of digits scanned (anode count).
- REFRESH_DIV, 100000: clock cycles each digit stays active.
- BLINK_FRAMES, 64: full frames per overflow blink half-period.

- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- value  in  4*N_DIGITS  hex nibbles; digit k = value[4k+3:4k].
- dp_mask  in  N_DIGITS  1 = light the decimal point of digit k.
- overflow  in  1  level from the datapath; 1 = blink all decimal points.
- load  in  1  strobe that captures value and dp_mask.
- load_pending  out  1  captured data not yet shown.
- an  out  N_DIGITS  anodes, active-low, one-hot-zero.
- seg  out  7  cathodes, active-low; seg[0]=CA … seg[6]=CG.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

## Operation
- Tick counter runs 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances.
- Digit index wraps from N_DIGITS-1 to 0. That wrap cycle is the frame boundary.
- Registers:
  - pending: value plus dp_mask.
  - shadow: displayed copy.
  - overflow_r: single flop on overflow.
  - frame counter.
  - blink_phase.
- Load handling:
  - load=1 captures value and dp_mask into pending and sets load_pending=1.
  - Back-to-back loads: last one wins.
- Frame boundary:
  - If load_pending=1, pending is copied to shadow and load_pending clears.
  - If load=1 in the boundary cycle, the live value/dp_mask are written to both pending and shadow, and load_pending stays 0.
- Hex decode of shadow nibble, as seg {CG..CA}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Decimal point:
  - dp = 0 if shadow_dp_mask[idx]=1, or if overflow_r=1 and blink_phase=1.
  - Otherwise dp = 1.
- Blink:
  - While overflow_r=0, the frame counter is held at 0 and blink_phase is held at 1, so overflow shows on its first frame.
  - While overflow_r=1, the frame counter increments at each frame boundary.
  - On reaching BLINK_FRAMES-1 it wraps and toggles blink_phase.
- Reset mid-scan:
  - Abandons the frame.
  - Discards pending and shadow contents.

## Timing
- All outputs are registered: one-cycle latency from the index/shadow state.
- Reset values, in the cycle after reset_n=0 is sampled:
  - an=all 1, seg=1111111, dp=1, frame_start=0, load_pending=0.
  - Internally: idx=0, tick=0, shadow=0, pending=0, frame counter=0, blink_phase=1, overflow_r=0.
- First edge after reset release: an=~1 (digit 0), seg=1000000 (nibble 0), frame_start=0. The post-reset frame does not pulse.
- Digit dwell is exactly REFRESH_DIV cycles. A frame is N_DIGITS*REFRESH_DIV cycles.
- Every later wrap to digit 0:
  - frame_start=1 in the same cycle an switches to digit 0.
  - The new shadow contents appear in that same cycle.
- Overflow:
  - overflow to dp effect: 2 cycles (overflow_r plus output register).
  - Blink period: 2*BLINK_FRAMES frames.
- Exactly one anode is low at any time after reset; anodes never overlap.

## Test plan
Bench parameters: REFRESH_DIV=4, N_DIGITS=8, BLINK_FRAMES=2.

1. Reset:
   - Stimulus: hold reset_n=0 for 3 cycles, then release.
   - Response: during reset an=FF, seg=7F, dp=1. After release an steps FE, FD, FB … 7F, FE, each for 4 cycles. frame_start pulses every 32 cycles, first pulse at cycle 32.
2. Decode:
   - Stimulus: load value=0x76543210, dp_mask=0, wait one frame.
   - Response: digits 0..7 show 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000. dp=1 on all.
3. Double buffer:
   - Stimulus: load 0xFFFFFFFF mid-frame.
   - Response: load_pending=1 and the old digits are unchanged until frame_start. On frame_start, digit 0 shows 0001110 and load_pending=0.
4. Load on boundary:
   - Stimulus: assert load in the exact wrap cycle with value=0x0000000A.
   - Response: digit 0 shows 0001000 in that frame. load_pending never rises.
5. Decimal point and overflow:
   - Stimulus: dp_mask=0x01, then overflow=1.
   - Response: digit 0 dp=0 always. Other digits have dp=0 for 2 frames, dp=1 for 2 frames, repeating.
   - Then drop overflow: only digit 0 dp=0 again within 2 cycles.
6. Mid-operation reset:
   - Stimulus: reset during digit 5 with load_pending=1.
   - Response: outputs return to their reset values. After release, digit 0 shows nibble 0 and load_pending=0.
